// File: rtl/seg7_scan_driver_if.sv
// Digit-source side of the 7-segment scan driver plus its board-pin outputs.
interface seg7_scan_driver_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] digits_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic                    load;
   logic                    en;
   logic [7:0]              seg;
   logic [NUM_DIGITS-1:0]   an;
   logic                    scan_tick;
   logic                    frame_done;

   // Datapath / counter logic that feeds the display.
   modport master (
      output digits_in, dp_in, load, en,
      input  seg, an, scan_tick, frame_done
   );

   // The scan driver itself.
   modport slave (
      input  digits_in, dp_in, load, en,
      output seg, an, scan_tick, frame_done
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: frame-synchronous shadow register, one digit per slot,
// hex decode with leading-zero blanking, per-digit decimal point and an all-dark guard at the
// start of every slot so the previous digit's pattern never ghosts onto the next anode.
module seg7_scan_driver #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned GUARD_CYCLES = 2,
   parameter bit          HEX_MODE     = 1'b1,
   parameter bit          LZ_BLANK     = 1'b1,
   parameter bit          SEG_ACT_LOW  = 1'b1,
   parameter bit          AN_ACT_LOW   = 1'b1
) (
   input logic               clk,
   input logic               rst,
   seg7_scan_driver_if.slave bus
);

   localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned DW    = 4 * NUM_DIGITS;

   localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0]      CNT_GUARD = CNT_W'(GUARD_CYCLES);
   localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [7:0]            SEG_OFF   = SEG_ACT_LOW ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] AN_OFF    = AN_ACT_LOW ? {NUM_DIGITS{1'b1}}
                                                            : {NUM_DIGITS{1'b0}};

   // Scan position
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             slot_wrap;
   logic             frame_wrap;

   // Pending (written by load) and active (shown this frame) digit words
   logic [DW-1:0]         pend_digits_q, act_digits_q;
   logic [NUM_DIGITS-1:0] pend_dp_q, act_dp_q;

   // Currently scanned digit
   logic [3:0]            cur_code;
   logic                  cur_dp;
   logic                  cur_blank;
   logic [NUM_DIGITS-1:0] cur_sel;
   logic                  upper_zero;

   // Output pipeline
   logic [7:0]            seg_pat, seg_d, seg_q;
   logic [NUM_DIGITS-1:0] an_pat, an_d, an_q;
   logic                  tick_q, frame_q;

   // Active-high gfedcba pattern for one 4-bit code.
   function automatic logic [6:0] decode(input logic [3:0] code);
      logic [6:0] p;
      unique case (code)
         4'h0: p = 7'h3F;
         4'h1: p = 7'h06;
         4'h2: p = 7'h5B;
         4'h3: p = 7'h4F;
         4'h4: p = 7'h66;
         4'h5: p = 7'h6D;
         4'h6: p = 7'h7D;
         4'h7: p = 7'h07;
         4'h8: p = 7'h7F;
         4'h9: p = 7'h6F;
         4'hA: p = HEX_MODE ? 7'h77 : 7'h00;
         4'hB: p = HEX_MODE ? 7'h7C : 7'h00;
         4'hC: p = HEX_MODE ? 7'h39 : 7'h00;
         4'hD: p = HEX_MODE ? 7'h5E : 7'h00;
         4'hE: p = HEX_MODE ? 7'h79 : 7'h00;
         4'hF: p = HEX_MODE ? 7'h71 : 7'h00;
      endcase
      return p;
   endfunction

   // Prescaler / digit-index next state; a frame ends when the last slot wraps.
   always_comb begin
      slot_wrap  = (cnt_q == CNT_LAST);
      frame_wrap = slot_wrap && (idx_q == IDX_LAST);
      cnt_d      = slot_wrap ? '0 : cnt_q + CNT_W'(1);
      idx_d      = idx_q;
      if (slot_wrap) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
   end

   // Prescaler and digit index registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

   // Pending register captures the caller's word whenever load is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_digits_q <= '0;
         pend_dp_q     <= '0;
      end else if (bus.load) begin
         pend_digits_q <= bus.digits_in;
         pend_dp_q     <= bus.dp_in;
      end
   end

   // Active register only changes on a frame boundary, so a frame never shows mixed data.
   // A load in the boundary cycle is not seen here until the next boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_digits_q <= '0;
         act_dp_q     <= '0;
      end else if (frame_wrap) begin
         act_digits_q <= pend_digits_q;
         act_dp_q     <= pend_dp_q;
      end
   end

   // Select the scanned digit; walking from the top tracks whether it and everything above
   // it are zero, which is the leading-zero condition.
   always_comb begin
      cur_code   = '0;
      cur_dp     = 1'b0;
      cur_blank  = 1'b0;
      cur_sel    = '0;
      upper_zero = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         upper_zero = upper_zero && (act_digits_q[4*k +: 4] == 4'd0);
         if (idx_q == IDX_W'(k)) begin
            cur_code   = act_digits_q[4*k +: 4];
            cur_dp     = act_dp_q[k];
            cur_sel[k] = 1'b1;
            cur_blank  = LZ_BLANK && (k != 0) && upper_zero;
         end
      end
   end

   // Build the next pin values: dark during the guard or when disabled, polarity last.
   always_comb begin
      seg_pat = 8'h00;
      an_pat  = '0;
      if (bus.en && (cnt_q >= CNT_GUARD)) begin
         an_pat  = cur_sel;
         seg_pat = {cur_dp, (cur_blank ? 7'h00 : decode(cur_code))};
      end
      seg_d = SEG_ACT_LOW ? ~seg_pat : seg_pat;
      an_d  = AN_ACT_LOW ? ~an_pat : an_pat;
   end

   // Registered pins and one-cycle pulses on the first cycle of each new slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q   <= SEG_OFF;
         an_q    <= AN_OFF;
         tick_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         seg_q   <= seg_d;
         an_q    <= an_d;
         tick_q  <= slot_wrap;
         frame_q <= frame_wrap;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.an         = an_q;
   assign bus.scan_tick  = tick_q;
   assign bus.frame_done = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a cycle-count reference model plus fixed expected patterns.
module tb_seg7_scan_driver;

   localparam int ND    = 4;
   localparam int RD    = 8;
   localparam int GC    = 2;
   localparam int FRAME = RD * ND;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

   seg7_scan_driver #(
      .NUM_DIGITS   (ND),
      .REFRESH_DIV  (RD),
      .GUARD_CYCLES (GC),
      .HEX_MODE     (1'b1),
      .LZ_BLANK     (1'b1),
      .SEG_ACT_LOW  (1'b1),
      .AN_ACT_LOW   (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int passed = 0;

   logic [6:0] seg_tab [16];

   // Reference model: position derived from edges since reset, frames every FRAME edges.
   int unsigned m_e;
   logic [15:0] m_pend_d, m_act_d;
   logic [3:0]  m_pend_dp, m_act_dp;
   logic [7:0]  exp_seg;
   logic [3:0]  exp_an;
   logic        exp_tick, exp_fd;

   function automatic logic [7:0] model_seg(input logic [15:0] d, input logic [3:0] dp,
                                            input int k);
      logic [15:0] upper;
      logic [7:0]  p;
      upper   = d >> (4 * k);
      p[7]    = dp[k];
      p[6:0]  = (k > 0 && upper == 16'd0) ? 7'h00 : seg_tab[upper[3:0]];
      return ~p;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_e       <= 0;
         m_pend_d  <= '0;
         m_pend_dp <= '0;
         m_act_d   <= '0;
         m_act_dp  <= '0;
         exp_seg   <= 8'hFF;
         exp_an    <= 4'hF;
         exp_tick  <= 1'b0;
         exp_fd    <= 1'b0;
      end else begin
         if (!bus.en || int'(m_e % RD) < GC) begin
            exp_seg <= 8'hFF;
            exp_an  <= 4'hF;
         end else begin
            exp_an  <= ~(4'b0001 << int'((m_e / RD) % ND));
            exp_seg <= model_seg(m_act_d, m_act_dp, int'((m_e / RD) % ND));
         end
         m_e      <= m_e + 1;
         exp_tick <= ((m_e + 1) % RD) == 0;
         exp_fd   <= ((m_e + 1) % FRAME) == 0;
         if (((m_e + 1) % FRAME) == 0) begin
            m_act_d  <= m_pend_d;
            m_act_dp <= m_pend_dp;
         end
         if (bus.load) begin
            m_pend_d  <= bus.digits_in;
            m_pend_dp <= bus.dp_in;
         end
      end
   end

   task automatic test_reset();
      logic [13:0] got, want;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int j = 1; j <= 13; j++) begin
         @(negedge clk);
         got  = {bus.seg, bus.an, bus.scan_tick, bus.frame_done};
         want = {exp_seg, exp_an, exp_tick, exp_fd};
         checks++;
         if (got !== want) $display("FAIL reset_run cyc %0d: got %h want %h", j, got, want);
         else passed++;
      end
      // Assert reset mid-slot, away from any clock edge.
      #2 rst = 1'b1;
      #1;
      got = {bus.seg, bus.an, bus.scan_tick, bus.frame_done};
      checks++;
      if (got !== {8'hFF, 4'hF, 2'b00}) $display("FAIL reset_async: got %h want %h", got,
                                                 {8'hFF, 4'hF, 2'b00});
      else passed++;
      @(negedge clk);
      got = {bus.seg, bus.an, bus.scan_tick, bus.frame_done};
      checks++;
      if (got !== {8'hFF, 4'hF, 2'b00}) $display("FAIL reset_held: got %h want %h", got,
                                                 {8'hFF, 4'hF, 2'b00});
      else passed++;
      rst = 1'b0;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         got  = {bus.seg, bus.an, bus.scan_tick, bus.frame_done};
         want = {exp_seg, exp_an, exp_tick, exp_fd};
         checks++;
         if (got !== want) $display("FAIL reset_release cyc %0d: got %h want %h", j, got, want);
         else passed++;
         checks++;
         if (bus.scan_tick !== ((j % RD) == 0))
            $display("FAIL reset_first_tick cyc %0d: got %b want %b", j, bus.scan_tick,
                     ((j % RD) == 0));
         else passed++;
      end
   endtask

   task automatic test_patterns();
      logic [15:0] pat_digits [3];
      logic [3:0]  pat_dp     [3];
      logic [31:0] pat_segs   [3];
      logic [13:0] got, want;
      logic [31:0] segs;
      logic [3:0]  one;
      int          off, ph, d;
      bit          found;
      pat_digits = '{16'h1234, 16'h00A0, 16'h0000};
      pat_dp     = '{4'b0000, 4'b0000, 4'b0100};
      pat_segs   = '{32'hF9A4B099, 32'hFFFF88C0, 32'hFF7FFFC0};
      one        = 4'b0001;
      for (int p = 0; p < 3; p++) begin
         @(negedge clk);
         bus.digits_in = pat_digits[p];
         bus.dp_in     = pat_dp[p];
         bus.load      = 1'b1;
         @(negedge clk);
         bus.load = 1'b0;
         found = 1'b0;
         for (int w = 0; w < 2 * FRAME && !found; w++) begin
            @(negedge clk);
            got  = {bus.seg, bus.an, bus.scan_tick, bus.frame_done};
            want = {exp_seg, exp_an, exp_tick, exp_fd};
            checks++;
            if (got !== want) $display("FAIL pattern%0d_wait: got %h want %h", p, got, want);
            else passed++;
            found = bus.frame_done;
         end
         checks++;
         if (!found) $display("FAIL pattern%0d_frame_done: got none want pulse", p);
         else passed++;
         segs = pat_segs[p];
         for (int j = 1; j <= FRAME; j++) begin
            @(negedge clk);
            off  = j - 1;
            ph   = off % RD;
            d    = off / RD;
            want = {(ph < GC) ? 8'hFF : segs[8*d +: 8], (ph < GC) ? 4'hF : ~(one << d),
                    (j % RD) == 0, j == FRAME};
            got  = {bus.seg, bus.an, bus.scan_tick, bus.frame_done};
            checks++;
            if (got !== want) $display("FAIL pattern%0d_frame cyc %0d: got %h want %h", p, j,
                                       got, want);
            else passed++;
         end
      end
   endtask

   task automatic test_boundary_load();
      logic [13:0] got, want;
      bit          found;
      @(negedge clk);
      bus.digits_in = 16'h1234;
      bus.dp_in     = 4'b0000;
      bus.load      = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      found = 1'b0;
      for (int w = 0; w < 2 * FRAME && !found; w++) begin
         @(negedge clk);
         found = bus.frame_done;
      end
      checks++;
      if (!found) $display("FAIL boundary_sync: got no frame_done want pulse");
      else passed++;
      repeat (FRAME - 1) @(negedge clk);
      // Load sampled on the very edge that ends the frame.
      bus.digits_in = 16'h5678;
      bus.load      = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      checks++;
      if (bus.frame_done !== 1'b1) $display("FAIL boundary_edge: got %b want 1", bus.frame_done);
      else passed++;
      for (int j = 1; j <= 2 * FRAME; j++) begin
         @(negedge clk);
         got  = {bus.seg, bus.an, bus.scan_tick, bus.frame_done};
         want = {exp_seg, exp_an, exp_tick, exp_fd};
         checks++;
         if (got !== want) $display("FAIL boundary_model cyc %0d: got %h want %h", j, got, want);
         else passed++;
         if (bus.an === 4'hE) begin
            checks++;
            if (bus.seg !== ((j <= FRAME) ? 8'h99 : 8'h80))
               $display("FAIL boundary_digit0 cyc %0d: got %h want %h", j, bus.seg,
                        ((j <= FRAME) ? 8'h99 : 8'h80));
            else passed++;
         end
      end
   endtask

   task automatic test_enable();
      logic [13:0] got, want;
      @(negedge clk);
      bus.en = 1'b0;
      for (int j = 1; j <= 20; j++) begin
         @(negedge clk);
         checks++;
         if ({bus.seg, bus.an} !== 12'hFFF)
            $display("FAIL enable_dark cyc %0d: got %h want fff", j, {bus.seg, bus.an});
         else passed++;
         got  = {bus.seg, bus.an, bus.scan_tick, bus.frame_done};
         want = {exp_seg, exp_an, exp_tick, exp_fd};
         checks++;
         if (got !== want) $display("FAIL enable_off_model cyc %0d: got %h want %h", j, got, want);
         else passed++;
      end
      bus.en = 1'b1;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         got  = {bus.seg, bus.an, bus.scan_tick, bus.frame_done};
         want = {exp_seg, exp_an, exp_tick, exp_fd};
         checks++;
         if (got !== want) $display("FAIL enable_resume cyc %0d: got %h want %h", j, got, want);
         else passed++;
      end
   endtask

   task automatic test_random();
      logic [13:0] got, want;
      logic [15:0] dg;
      for (int j = 1; j <= 800; j++) begin
         @(negedge clk);
         got  = {bus.seg, bus.an, bus.scan_tick, bus.frame_done};
         want = {exp_seg, exp_an, exp_tick, exp_fd};
         checks++;
         if (got !== want) $display("FAIL random cyc %0d: got %h want %h", j, got, want);
         else passed++;
         for (int k = 0; k < ND; k++)
            dg[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         bus.digits_in = dg;
         bus.dp_in     = 4'($urandom);
         bus.load      = ($urandom_range(0, 7) == 0);
         bus.en        = ($urandom_range(0, 15) != 0);
      end
      @(negedge clk);
      bus.load = 1'b0;
      bus.en   = 1'b1;
   endtask

   initial begin
      seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      bus.digits_in = '0;
      bus.dp_in     = '0;
      bus.load      = 1'b0;
      bus.en        = 1'b1;
      test_reset();
      test_patterns();
      test_boundary_load();
      test_enable();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
